// File: rtl/led_latch_rx.sv
// Receive side of the LED driver serial latch link: oversamples SCLK/LAT/SIN,
// shifts frames in MSB-first and decodes control or grayscale latches on LAT rise.
module led_latch_rx #(
  parameter int LATCH_SIZE  = 769,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic                  CLK_10M,
  input  logic                  nReset,
  input  logic                  SCLK,
  input  logic                  LAT,
  input  logic                  SIN,
  output logic [LATCH_SIZE-2:0] gs_data,
  output logic                  gs_valid,
  output logic [335:0]          dc_data,
  output logic [8:0]            mc,
  output logic [20:0]           bc,
  output logic [4:0]            fc,
  output logic                  ctrl_valid,
  output logic                  frame_err,
  output logic [ERR_W-1:0]      err_count,
  output logic [9:0]            bit_count
);

  localparam int GS_W = LATCH_SIZE - 1;

  typedef enum logic [1:0] {IDLE, SHIFTING, DECODE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, lat_sync, sin_sync;
  logic                   sclk_d, lat_d;
  logic                   sclk_rise, lat_rise, sin_s;
  logic [LATCH_SIZE-1:0]  sreg, sreg_shift;
  logic [9:0]             cnt_shift, cnt_nxt;
  logic                   take_gs, take_ctrl, bad;
  state_t                 state, state_nxt;

  always_ff @(posedge CLK_10M or negedge nReset) begin
    if (!nReset) begin
      sclk_sync <= '0;
      lat_sync  <= '0;
      sin_sync  <= '0;
      sclk_d    <= 1'b0;
      lat_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      lat_sync  <= {lat_sync[SYNC_STAGES-2:0], LAT};
      sin_sync  <= {sin_sync[SYNC_STAGES-2:0], SIN};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      lat_d     <= lat_sync[SYNC_STAGES-1];
    end
  end

  // SIN leaves the chain at the same depth as SCLK so each bit lines up with its edge
  assign sin_s      = sin_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
  assign lat_rise   = lat_sync[SYNC_STAGES-1] & ~lat_d;
  assign sreg_shift = sclk_rise ? {sreg[LATCH_SIZE-2:0], sin_s} : sreg;

  // Decode sees the post-shift register and count, so a final SCLK edge
  // landing in the same cycle as LAT still completes the frame.
  always_comb begin
    cnt_shift = bit_count;
    if (sclk_rise && bit_count != '1) cnt_shift = bit_count + 10'd1;
    cnt_nxt   = cnt_shift;
    if (state == DECODE) cnt_nxt = sclk_rise ? 10'd1 : 10'd0;
    take_gs   = 1'b0;
    take_ctrl = 1'b0;
    bad       = 1'b0;
    state_nxt = (cnt_nxt != '0) ? SHIFTING : IDLE;
    if (lat_rise) begin
      state_nxt = DECODE;
      if (cnt_shift == 10'(LATCH_SIZE)) begin
        take_ctrl = sreg_shift[LATCH_SIZE-1];
        take_gs   = ~sreg_shift[LATCH_SIZE-1];
      end else begin
        bad = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_10M or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_count  <= '0;
      gs_data    <= '0;
      gs_valid   <= 1'b0;
      dc_data    <= '0;
      mc         <= '0;
      bc         <= '0;
      fc         <= '0;
      ctrl_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_shift;
      bit_count  <= cnt_nxt;
      gs_valid   <= take_gs;
      ctrl_valid <= take_ctrl;
      frame_err  <= bad;
      if (take_gs) gs_data <= sreg_shift[GS_W-1:0];
      if (take_ctrl) begin
        dc_data <= sreg_shift[335:0];
        mc      <= sreg_shift[344:336];
        bc      <= sreg_shift[365:345];
        fc      <= sreg_shift[370:366];
      end
      if (bad && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule
